// File: rtl/asym_ram_stream_reader.sv
// rtl/asym_ram_stream_reader.sv - burst reader for the asymmetric RAM narrow port
// Issues narrow reads, absorbs the 1-cycle RAM latency and streams words out with last/done.
module asym_ram_stream_reader #(
  parameter int WIDTHB     = 48,
  parameter int ADDRWIDTHB = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDRWIDTHB-1:0] base_addr,
  input  logic [ADDRWIDTHB:0]   num_words,
  output logic [ADDRWIDTHB-1:0] ram_addr,
  input  logic [WIDTHB-1:0]     ram_dout,
  output logic [WIDTHB-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = ADDRWIDTHB + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                r_state;
  logic [ADDRWIDTHB-1:0] r_ram_addr;
  logic [CW-1:0]         r_num;
  logic [CW-1:0]         r_issued;
  logic [CW-1:0]         r_beat;
  logic [1:0]            r_inflight;
  logic [WIDTHB-1:0]     r_fifo [4];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [2:0]            r_count;
  logic                  r_done;

  logic [2:0]            w_credit;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_beat;

  // Credit counts every word that may still land in the FIFO, so issue never
  // needs to look at out_ready and the 4-entry FIFO cannot overflow.
  assign w_credit    = r_count + {2'b00, r_inflight[0]} + {2'b00, r_inflight[1]};
  assign w_issue     = (r_state == S_RUN) && (r_issued < r_num) && (w_credit < 3'd4);
  assign w_push      = r_inflight[0];
  assign w_pop       = out_valid && out_ready;
  assign w_last_beat = (r_beat == (r_num - CW'(1)));

  assign ram_addr  = r_ram_addr;
  assign out_valid = (r_count != 3'd0);
  assign out_data  = r_fifo[r_rd_ptr];
  assign out_last  = out_valid && w_last_beat;
  assign busy      = (r_state == S_RUN);
  assign done      = r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ram_addr <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_beat     <= '0;
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      r_done     <= 1'b0;
      r_inflight <= {r_inflight[0], w_issue};

      if (w_push) begin
        r_fifo[r_wr_ptr] <= ram_dout;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              r_ram_addr <= base_addr;
              r_num      <= num_words;
              r_issued   <= '0;
              r_beat     <= '0;
              r_state    <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_ram_addr <= r_ram_addr + ADDRWIDTHB'(1);
            r_issued   <= r_issued + CW'(1);
          end
          if (w_pop) begin
            r_beat <= r_beat + CW'(1);
            if (w_last_beat) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/asym_ram_stream_reader.md
Name: asym_ram_stream_reader

Overview:
- Sits directly downstream of the wide-write/narrow-read asymmetric RAM, in the same clock domain as its narrow read port.
- Controller issues a burst request (base address, word count).
- Block drives the RAM narrow read address and absorbs the RAM's 1-cycle registered read latency.
- Delivers the words as a valid/ready stream with a last marker, at full throughput (1 word/cycle) under continuous ready.

Parameters:
WIDTHB, 48, narrow RAM word width and output data width
ADDRWIDTHB, 10, narrow RAM address width; address space 2^ADDRWIDTHB words

Ports:
clk  in  1  single clock; also drives the RAM narrow read clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  burst request pulse; sampled only in IDLE
base_addr  in  ADDRWIDTHB  first narrow word address of the burst
num_words  in  ADDRWIDTHB+1  burst length, 0..2^ADDRWIDTHB
ram_addr  out  ADDRWIDTHB  to RAM narrow read address
ram_dout  in  WIDTHB  from RAM narrow read data (registered inside RAM)
out_data  out  WIDTHB  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready from consumer
out_last  out  1  high with the final beat of the burst
busy  out  1  high while not IDLE
done  out  1  1-cycle pulse when the burst completes

Behaviour:
- Reset: all outputs 0. State IDLE. FIFO empty. Counters cleared. An asserted reset_n mid-burst discards the burst; no done pulse.
- States: IDLE, RUN.
  - IDLE, start=1, num_words>0: latch base_addr into ram_addr, latch num_words, clear issue/beat counters, go to RUN.
  - IDLE, start=1, num_words=0: stay IDLE, pulse done next cycle, emit no beat.
  - start in RUN is ignored; parameters are not re-latched.
- Read pipeline: two in-flight stages.
  - Issue cycle: ram_addr is stable and RAM samples it at the cycle-ending edge.
  - Next cycle: ram_dout holds that word and is pushed into the FIFO at the following edge.
  - In-flight tracking is a 2-bit shift of issue flags.
- Issue condition: RUN, issued < num_words, and fifo_count + inflight < 4.
  - On issue: ram_addr <= ram_addr+1, modulo 2^ADDRWIDTHB (wraps, e.g. 0x3FF -> 0x000); issued increments.
  - Without issue, ram_addr holds.
  - The condition uses no combinational term from out_ready.
- FIFO: 4 entries, WIDTHB bits. Simultaneous push and pop keeps the count. The credit rule guarantees the FIFO never overflows; the bench asserts this.
- Output: out_valid = FIFO non-empty; out_data = FIFO head. A beat transfers when out_valid and out_ready are both high.
  - out_valid and out_data are held stable while out_ready=0.
  - out_last = out_valid and (beat index == num_words-1).
- Latency: start sampled at edge E0 -> first issue in the cycle after E0 -> first out_valid after edge E2.
  - With out_ready held high, beats are contiguous, one per cycle.
- Completion: on transfer of the last beat, done=1 for the next cycle, busy=0, state IDLE. A new start is accepted on the edge after done.
- Back-to-back bursts: no overlap; each burst fully drains before the next is accepted.
- Width rules: counters are ADDRWIDTHB+1 bits so num_words=2^ADDRWIDTHB is legal.

Test Plan:
- Continuous flow: RAM preloaded with word[n]=n; start, base=0x010, num=4, out_ready=1 -> beats 0x010..0x013 on 4 consecutive cycles, first out_valid after E2, out_last on 0x013, done 1 cycle later.
- Backpressure: base=0x000, num=8, out_ready toggles 1/0 each cycle, then held 0 for 5 cycles -> all 8 words in order, none dropped or duplicated; data stable while stalled; no FIFO overflow; ram_addr stalls when credit exhausted.
- Wrap-around: base=0x3FE, num=4 -> ram_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; data matches those addresses.
- Zero length and full length: num=0 -> done pulse, no out_valid, busy stays 0. num=1024, base=0x200 -> 1024 beats, single out_last.
- Start while busy: second start pulse mid-burst with different base/num -> ignored; original burst completes unchanged.
- Reset mid-burst: assert reset_n low after 3 of 8 beats -> outputs 0 immediately, no done. A new burst after release runs correctly from its own base.
